// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: N masters share one slave port, grant held for the
// whole CYC tenure, optional watchdog answers a silent slave with a forced ERR.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_ADR,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_DAT_W,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_SEL,
    input  logic [N_MASTERS-1:0]                   m_CYC,
    input  logic [N_MASTERS-1:0]                   m_STB,
    input  logic [N_MASTERS-1:0]                   m_WE,
    output logic [WB_DATA_WIDTH-1:0]               m_DAT_R,
    output logic [N_MASTERS-1:0]                   m_ACK,
    output logic [N_MASTERS-1:0]                   m_ERR,
    output logic [WB_ADDR_WIDTH-1:0]               s_ADR,
    output logic [WB_DATA_WIDTH-1:0]               s_DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0]             s_SEL,
    output logic                                   s_CYC,
    output logic                                   s_STB,
    output logic                                   s_WE,
    input  logic [WB_DATA_WIDTH-1:0]               s_DAT_R,
    input  logic                                   s_ACK,
    input  logic                                   s_ERR,
    output logic [N_MASTERS-1:0]                   gnt_o,
    output logic                                   timeout_o
);
    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;
    localparam int SW    = WB_DATA_WIDTH / 8;
    localparam int IW    = $clog2(N_MASTERS);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int CW    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WD_LAST = WD_EN ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        wd_q, wd_d;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic                 g_cyc, g_stb, g_we;
    logic [AW-1:0]        g_adr;
    logic [DW-1:0]        g_dat;
    logic [SW-1:0]        g_sel;
    logic                 busy, stall, fire;

    // Rotating priority: first requester at or after last+1, wrapping past N-1 to 0.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = int'(last_q) + i;
            if (cand >= N_MASTERS) cand = cand - N_MASTERS;
            if (!win_found && m_CYC[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // AND-OR mux keyed by the one-hot grant; all zero when nobody holds it.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (gnt_q[i]) begin
                g_cyc = m_CYC[i];
                g_stb = m_STB[i];
                g_we  = m_WE[i];
                g_adr = m_ADR[i*AW +: AW];
                g_dat = m_DAT_W[i*DW +: DW];
                g_sel = m_SEL[i*SW +: SW];
            end
        end
    end

    assign busy  = (state_q == BUSY);
    assign stall = busy && g_stb && !s_ACK && !s_ERR;
    assign fire  = WD_EN && stall && (wd_q == CW'(WD_LAST));

    always_comb begin
        wd_d = '0;
        if (WD_EN && stall)
            wd_d = (wd_q == CW'(TIMEOUT_CYCLES)) ? wd_q : wd_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    gnt_d   = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                    last_d  = win_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (fire) begin
                    state_d = TOUT;
                end
            end
            TOUT: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Slave side sees the granted master only in BUSY; TOUT drops the cycle.
    assign s_CYC     = busy && g_cyc;
    assign s_STB     = busy && g_stb;
    assign s_WE      = busy && g_we;
    assign s_ADR     = busy ? g_adr : '0;
    assign s_DAT_W   = busy ? g_dat : '0;
    assign s_SEL     = busy ? g_sel : '0;

    assign m_DAT_R   = s_DAT_R;
    assign m_ACK     = (busy && s_ACK) ? gnt_q : '0;
    assign m_ERR     = ((busy && s_ERR) || state_q == TOUT) ? gnt_q : '0;
    assign gnt_o     = gnt_q;
    assign timeout_o = (state_q == TOUT);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a 2-master instance with an 8-cycle watchdog and a
// 4-master instance for pointer wrap-around.
module tb_wb_rr_arbiter;
    logic clk_i = 1'b0;
    logic rstn_i;
    always #5 clk_i = ~clk_i;

    // 2-master instance
    logic [63:0] m_ADR, m_DAT_W;
    logic [7:0]  m_SEL;
    logic [1:0]  m_CYC, m_STB, m_WE, m_ACK, m_ERR, gnt_o;
    logic [31:0] m_DAT_R, s_ADR, s_DAT_W, s_DAT_R;
    logic [3:0]  s_SEL;
    logic        s_CYC, s_STB, s_WE, s_ACK, s_ERR, timeout_o;

    wb_rr_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m_ADR(m_ADR), .m_DAT_W(m_DAT_W), .m_SEL(m_SEL),
        .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE),
        .m_DAT_R(m_DAT_R), .m_ACK(m_ACK), .m_ERR(m_ERR),
        .s_ADR(s_ADR), .s_DAT_W(s_DAT_W), .s_SEL(s_SEL),
        .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE),
        .s_DAT_R(s_DAT_R), .s_ACK(s_ACK), .s_ERR(s_ERR),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    // 4-master instance, watchdog off
    logic [127:0] m4_ADR, m4_DAT_W;
    logic [15:0]  m4_SEL;
    logic [3:0]   m4_CYC, m4_STB, m4_WE, m4_ACK, m4_ERR, gnt4;
    logic [31:0]  m4_DAT_R, s4_ADR, s4_DAT_W;
    logic [3:0]   s4_SEL;
    logic         s4_CYC, s4_STB, s4_WE, tout4;

    wb_rr_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(0)) dut4 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m_ADR(m4_ADR), .m_DAT_W(m4_DAT_W), .m_SEL(m4_SEL),
        .m_CYC(m4_CYC), .m_STB(m4_STB), .m_WE(m4_WE),
        .m_DAT_R(m4_DAT_R), .m_ACK(m4_ACK), .m_ERR(m4_ERR),
        .s_ADR(s4_ADR), .s_DAT_W(s4_DAT_W), .s_SEL(s4_SEL),
        .s_CYC(s4_CYC), .s_STB(s4_STB), .s_WE(s4_WE),
        .s_DAT_R(32'h0), .s_ACK(1'b0), .s_ERR(1'b0),
        .gnt_o(gnt4), .timeout_o(tout4)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rstn_i  = 1'b0;
        m_ADR   = '0; m_DAT_W = '0; m_SEL = '1;
        m_CYC   = 2'b11; m_STB = 2'b11; m_WE = 2'b00;
        s_DAT_R = '0; s_ACK = 1'b0; s_ERR = 1'b0;
        m4_ADR  = '0; m4_DAT_W = '0; m4_SEL = '0;
        m4_CYC  = '0; m4_STB = '0; m4_WE = '0;

        // reset with both masters requesting
        repeat (2) tick();
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_scyc", s_CYC, 1'b0);
        chk("rst_sstb", s_STB, 1'b0);
        chk("rst_ack", m_ACK, 2'b00);
        chk("rst_tout", timeout_o, 1'b0);
        rstn_i = 1'b1;
        tick(); #1;
        chk("first_gnt", gnt_o, 2'b01);
        chk("first_scyc", s_CYC, 1'b1);

        // fairness: each master drops CYC on its ACK
        s_ACK = 1'b1; m_CYC = 2'b10; #1;
        chk("fair_ack0", m_ACK, 2'b01);
        tick(); s_ACK = 1'b0; m_CYC = 2'b11; #1;
        chk("fair_idle0", gnt_o, 2'b00);
        chk("fair_idle0_ack", m_ACK, 2'b00);
        tick(); #1;
        chk("fair_gnt1", gnt_o, 2'b10);
        s_ACK = 1'b1; m_CYC = 2'b01; #1;
        chk("fair_ack1", m_ACK, 2'b10);
        tick(); s_ACK = 1'b0; m_CYC = 2'b11; #1;
        chk("fair_idle1", gnt_o, 2'b00);
        tick(); #1;
        chk("fair_gnt0", gnt_o, 2'b01);

        // lock: m0 does four reads while m1 keeps requesting
        m_ADR[63:32] = 32'h1234_0000;
        for (int k = 0; k < 4; k++) begin
            m_ADR[31:0] = 32'h6000_1000 + 32'(4 * k);
            s_DAT_R     = 32'hDEAD_BEEF + 32'(k);
            s_ACK       = 1'b1;
            if (k == 3) m_CYC = 2'b10;
            #1;
            chk($sformatf("lock_adr%0d", k), s_ADR, 32'h6000_1000 + 32'(4 * k));
            chk($sformatf("lock_dat%0d", k), m_DAT_R, 32'hDEAD_BEEF + 32'(k));
            chk($sformatf("lock_ack%0d", k), m_ACK, 2'b01);
            chk($sformatf("lock_gnt%0d", k), gnt_o, 2'b01);
            tick();
        end
        s_ACK = 1'b0; #1;
        chk("lock_idle", gnt_o, 2'b00);
        tick(); #1;
        chk("lock_m1_gnt", gnt_o, 2'b10);
        chk("lock_m1_adr", s_ADR, 32'h1234_0000);
        m_CYC = 2'b00;
        tick(); #1;
        chk("lock_m1_rel", gnt_o, 2'b00);

        // watchdog: slave silent for 8 strobe cycles
        m_CYC = 2'b01;
        tick();
        repeat (7) tick();
        #1;
        chk("wd_cyc8_err", m_ERR, 2'b00);
        chk("wd_cyc8_scyc", s_CYC, 1'b1);
        tick(); #1;
        chk("wd_err", m_ERR, 2'b01);
        chk("wd_tout", timeout_o, 1'b1);
        chk("wd_scyc", s_CYC, 1'b0);
        chk("wd_sstb", s_STB, 1'b0);
        m_CYC = 2'b00;
        tick(); #1;
        chk("wd_after_tout", timeout_o, 1'b0);
        chk("wd_after_gnt", gnt_o, 2'b00);
        chk("wd_after_err", m_ERR, 2'b00);

        // ACK arriving on the 8th strobe cycle beats the watchdog
        m_CYC = 2'b01;
        tick();
        repeat (7) tick();
        s_ACK = 1'b1; m_CYC = 2'b00; #1;
        chk("wd_ack8_ack", m_ACK, 2'b01);
        chk("wd_ack8_err", m_ERR, 2'b00);
        tick(); s_ACK = 1'b0; #1;
        chk("wd_ack8_tout", timeout_o, 1'b0);
        chk("wd_ack8_err2", m_ERR, 2'b00);
        chk("wd_ack8_gnt", gnt_o, 2'b00);

        // async reset in the middle of a write
        m_CYC = 2'b10; m_STB = 2'b10; m_WE = 2'b10;
        tick(); #1;
        chk("ar_gnt", gnt_o, 2'b10);
        chk("ar_swe", s_WE, 1'b1);
        s_ACK = 1'b1; rstn_i = 1'b0; #1;
        chk("ar_scyc", s_CYC, 1'b0);
        chk("ar_gnt0", gnt_o, 2'b00);
        chk("ar_ack", m_ACK, 2'b00);
        tick();
        rstn_i = 1'b1; s_ACK = 1'b0; m_CYC = 2'b00; m_STB = 2'b00; m_WE = 2'b00;

        // pointer wrap on the 4-master instance
        m4_CYC = 4'b1100;
        tick(); #1;
        chk("wrap_m2", gnt4, 4'b0100);
        m4_CYC = 4'b1000;
        tick(); #1;
        chk("wrap_idle_a", gnt4, 4'b0000);
        tick(); #1;
        chk("wrap_m3", gnt4, 4'b1000);
        m4_CYC = 4'b0101;
        tick(); #1;
        chk("wrap_idle_b", gnt4, 4'b0000);
        tick(); #1;
        chk("wrap_m0", gnt4, 4'b0001);
        m4_CYC = 4'b0100;
        tick(); m4_CYC = 4'b0101; #1;
        chk("wrap_idle_c", gnt4, 4'b0000);
        tick(); #1;
        chk("wrap_next_m2", gnt4, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
